multich_sample_fifo: RTL and testbench
======================================

MULTICH_SAMPLE_FIFO -- requirements
Module: multich_sample_fifo

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 2, number of channels; NUM_CH_LOG2, default 1, log2 of NUM_CH; DEPTH, default 16, entries per channel; DEPTH_LOG2, default 4, log2 of DEPTH.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high global reset.
REQ-004 rst_ch  input  NUM_CH  synchronous, active-high per-channel reset.
REQ-005 wr_en_i  input  NUM_CH  per-channel push strobe from upstream source.
REQ-006 wr_data_i  input  24*NUM_CH  push data; channel c occupies bits [24c+23:24c], two's complement.
REQ-007 full_o  output  NUM_CH  channel holds DEPTH entries.
REQ-008 pop_i  input  NUM_CH  per-channel sample request; connects to the resampler pop_o.
REQ-009 ack_o  output  NUM_CH  one-cycle response pulse per accepted pop; connects to the resampler ack_i.
REQ-010 data_o  output  24*NUM_CH  response data, same slicing as wr_data_i; connects to the resampler data_i.
REQ-011 underrun_o  output  NUM_CH  one-cycle pulse: pop served while the channel was empty.
REQ-012 overflow_o  output  NUM_CH  one-cycle pulse: push dropped because the channel was full.
REQ-013 level_o  output  (DEPTH_LOG2+1)*NUM_CH  per-channel occupancy, 0..DEPTH.

Function
REQ-014 Each channel SHALL be an independent FIFO; no channel's activity SHALL affect another channel's outputs.
REQ-015 A pop_i[c] high at edge N SHALL produce ack_o[c] high for exactly cycle N+1, with the head entry on data_o slice c in that cycle.
REQ-016 The data_o slice SHALL hold its last acked value until the next ack on that channel.
REQ-017 pop_i[c] high on consecutive edges SHALL be treated as separate requests: one ack per cycle, one entry consumed per request.
REQ-018 A pop on an empty channel SHALL still be acked at N+1 with data 24'h000000 and underrun_o[c] pulsed; level stays 0.
REQ-019 A push when level<DEPTH SHALL append wr_data_i slice c; level increments at the next edge.
REQ-020 A push at level==DEPTH without a same-cycle pop SHALL be dropped with overflow_o[c] pulsed; FIFO contents SHALL be unchanged.
REQ-021 A simultaneous push and pop at level==DEPTH SHALL accept both; level stays DEPTH.
REQ-022 A simultaneous push and pop at level==0 SHALL be treated as an underrun (zero data, underrun pulse); the pushed word SHALL be stored and level becomes 1 (no bypass).
REQ-023 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap modulo DEPTH; full/empty SHALL derive from level, not from pointer equality.
REQ-024 full_o[c] SHALL equal (level==DEPTH), combinationally from registered state.
REQ-025 Per-channel response control SHALL be a two-state machine, IDLE and ACK: pop moves it to ACK; ACK returns to IDLE unless another pop is present, in which case it stays in ACK.

Reset
REQ-026 rst SHALL clear all pointers, levels, ack_o, underrun_o and overflow_o, and set data_o to zero; storage contents need not be cleared.
REQ-027 rst_ch[c] SHALL do the same for channel c only.
REQ-028 A reset asserted in the cycle a pop is sampled SHALL cancel that pop (no ack); a reset asserted in the cycle an ack is due SHALL suppress that ack.
REQ-029 Pushes and pops SHALL be ignored while the applicable reset is high.

Structure
REQ-030 A shared package SHALL hold the sample width constant (24) and the zero-sample constant, shared with the resampler.
REQ-031 One sub-module, sample_fifo_ch (single-channel FIFO plus IDLE/ACK machine), SHALL be instantiated NUM_CH times by generate.

Verification
REQ-032 Push 0x000001..0x000003 on ch0, then pop ch0 three times, 64 cycles apart -> each ack one cycle after its pop, data 1,2,3; ch1 ack stays 0.
REQ-033 Pop ch1 while empty -> ack_o[1] at N+1, data 0x000000, underrun_o[1] pulse, level_o ch1 = 0.
REQ-034 Push 17 words into ch0 (DEPTH=16) -> full_o[0]=1 after 16, overflow_o[0] pulse on the 17th; 16 pops return words 1..16 in order.
REQ-035 At full, push 0xABCDEF and pop in the same cycle -> ack data is word 1, level stays 16, final entry is 0xABCDEF.
REQ-036 Push 20 and pop 20 words across the wrap point -> data order preserved; level returns to 0.
REQ-037 Pop ch0 and ch1 together, then assert rst_ch[0] on the ack cycle -> ack_o[0] suppressed, ack_o[1] delivered, ch0 level 0.

Source files
------------

// File: rtl/multich_sample_fifo_pkg.sv
// -----------------------------------------------------------------------------
// multich_sample_fifo_pkg
// Shared definitions for the multi-channel sample FIFO and the resampler that
// consumes it.
//   SAMPLE_W     : width of one audio sample (two's complement)
//   sample_t     : one sample word
//   SAMPLE_ZERO  : value returned for a pop that finds its channel empty
//   ack_state_e  : per-channel response state (IDLE / ACK)
// -----------------------------------------------------------------------------
package multich_sample_fifo_pkg;

   localparam int SAMPLE_W = 24;

   typedef logic [SAMPLE_W-1:0] sample_t;

   localparam sample_t SAMPLE_ZERO = '0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } ack_state_e;

endpackage

// File: rtl/multich_sample_fifo_if.sv
// -----------------------------------------------------------------------------
// multich_sample_fifo_if
// Bundles the push side (from the upstream source) and the pop/ack side (to
// the resampler) of the multi-channel sample FIFO.
//   wr_en_i    : per-channel push strobe
//   wr_data_i  : push data, channel c in bits [24c+23:24c]
//   full_o     : per-channel full flag
//   pop_i      : per-channel sample request
//   ack_o      : per-channel one-cycle response pulse
//   data_o     : response data, same slicing as wr_data_i
//   underrun_o : pop served from an empty channel
//   overflow_o : push dropped on a full channel
//   level_o    : per-channel occupancy, (DEPTH_LOG2+1) bits per channel
// master = source/resampler side, slave = the FIFO.
// -----------------------------------------------------------------------------
interface multich_sample_fifo_if
   import multich_sample_fifo_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int DEPTH_LOG2 = 4
) ();

   logic [NUM_CH-1:0]                  wr_en_i;
   logic [SAMPLE_W*NUM_CH-1:0]         wr_data_i;
   logic [NUM_CH-1:0]                  full_o;
   logic [NUM_CH-1:0]                  pop_i;
   logic [NUM_CH-1:0]                  ack_o;
   logic [SAMPLE_W*NUM_CH-1:0]         data_o;
   logic [NUM_CH-1:0]                  underrun_o;
   logic [NUM_CH-1:0]                  overflow_o;
   logic [(DEPTH_LOG2+1)*NUM_CH-1:0]   level_o;

   modport master (
      output wr_en_i, wr_data_i, pop_i,
      input  full_o, ack_o, data_o, underrun_o, overflow_o, level_o
   );

   modport slave (
      input  wr_en_i, wr_data_i, pop_i,
      output full_o, ack_o, data_o, underrun_o, overflow_o, level_o
   );

endinterface

// File: rtl/multich_sample_fifo_ch.sv
// -----------------------------------------------------------------------------
// sample_fifo_ch
// One channel of the sample FIFO: DEPTH-entry circular buffer plus the
// IDLE/ACK response machine that answers each pop one cycle later.
//   clk        : clock, rising edge
//   i_rst      : synchronous active-high reset (global OR per-channel)
//   i_wr_en    : push strobe
//   i_wr_data  : push sample
//   i_pop      : sample request
//   o_full     : level == DEPTH
//   o_ack      : response pulse, cycle after the pop
//   o_data     : response sample, held until the next ack
//   o_underrun : pop found the channel empty
//   o_overflow : push dropped because the channel was full
//   o_level    : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module sample_fifo_ch
   import multich_sample_fifo_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_wr_en,
   input  sample_t               i_wr_data,
   input  logic                  i_pop,
   output logic                  o_full,
   output logic                  o_ack,
   output sample_t               o_data,
   output logic                  o_underrun,
   output logic                  o_overflow,
   output logic [DEPTH_LOG2:0]   o_level
);

   localparam int LW = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2:0] LP_FULL_LEVEL = LW'(DEPTH);

   sample_t                 r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   r_rd_ptr;
   logic [DEPTH_LOG2-1:0]   r_wr_ptr;
   logic [DEPTH_LOG2:0]     r_level;
   ack_state_e              r_state;
   sample_t                 r_data;
   logic                    r_underrun;
   logic                    r_overflow;

   logic                    w_empty;
   logic                    w_full;
   logic                    w_pop_hit;
   logic                    w_push_acc;

   // Empty/full come from the occupancy counter rather than pointer equality,
   // so a full buffer (rd == wr) is never mistaken for an empty one. A push on
   // a full channel is still accepted when a pop frees the head slot in the
   // same cycle; on an empty channel the pop is an underrun and the push is
   // simply stored, with no bypass to the response.
   always_comb begin
      w_empty    = (r_level == '0);
      w_full     = (r_level == LP_FULL_LEVEL);
      w_pop_hit  = i_pop & ~w_empty;
      w_push_acc = i_wr_en & (~w_full | i_pop);
   end

   // Sample storage. Not reset: stale contents are unreachable once the
   // pointers and level are cleared. When full with a simultaneous push and
   // pop, rd and wr point at the same slot; the response register picks up the
   // old head value before this write lands, which is the intended order.
   always_ff @(posedge clk) begin
      if (!i_rst && w_push_acc) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers, level and the IDLE/ACK response machine. Every pop moves the
   // machine into ACK for the following cycle; back-to-back pops keep it there
   // so each request still gets its own ack and consumes its own entry. The
   // response data register only changes on a pop, which gives the
   // hold-until-next-ack behaviour for free.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_level    <= '0;
         r_state    <= ST_IDLE;
         r_data     <= SAMPLE_ZERO;
         r_underrun <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (i_pop)  r_state <= ST_ACK;
            ST_ACK:  if (!i_pop) r_state <= ST_IDLE;
            default:             r_state <= ST_IDLE;
         endcase

         if (i_pop) begin
            r_data <= w_pop_hit ? r_mem[r_rd_ptr] : SAMPLE_ZERO;
         end

         r_underrun <= i_pop & w_empty;
         r_overflow <= i_wr_en & w_full & ~i_pop;

         if (w_pop_hit) begin
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         end
         if (w_push_acc) begin
            r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         end

         r_level <= r_level + LW'(w_push_acc) - LW'(w_pop_hit);
      end
   end

   // The pulse outputs are masked by the reset itself so that a reset raised
   // during the cycle an ack is due suppresses that ack immediately, rather
   // than one cycle too late.
   always_comb begin
      o_full     = w_full;
      o_ack      = (r_state == ST_ACK) & ~i_rst;
      o_data     = r_data;
      o_underrun = r_underrun & ~i_rst;
      o_overflow = r_overflow & ~i_rst;
      o_level    = r_level;
   end

endmodule

// File: rtl/multich_sample_fifo.sv
// -----------------------------------------------------------------------------
// multich_sample_fifo
// NUM_CH independent sample FIFOs feeding a resampler. Each channel answers a
// pop with a one-cycle ack and the head sample one cycle later, returning zero
// with an underrun pulse when empty, and drops pushes into a full channel with
// an overflow pulse.
//   clk     : clock, rising edge
//   rst     : synchronous active-high global reset
//   rst_ch  : synchronous active-high per-channel reset
//   bus     : slave side of multich_sample_fifo_if (push, pop/ack, status)
// -----------------------------------------------------------------------------
module multich_sample_fifo
   import multich_sample_fifo_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int NUM_CH_LOG2 = 1,
   parameter int DEPTH       = 16,
   parameter int DEPTH_LOG2  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     rst_ch,
   multich_sample_fifo_if.slave  bus
);

   localparam int LW = DEPTH_LOG2 + 1;

   logic [NUM_CH-1:0]          w_ch_rst;
   logic [NUM_CH-1:0]          w_full;
   logic [NUM_CH-1:0]          w_ack;
   logic [NUM_CH-1:0]          w_underrun;
   logic [NUM_CH-1:0]          w_overflow;
   logic [SAMPLE_W*NUM_CH-1:0] w_data;
   logic [LW*NUM_CH-1:0]       w_level;

   // Catch inconsistent log2 parameters at elaboration; the pointers rely on
   // DEPTH being exactly 2**DEPTH_LOG2 so they wrap for free.
   if (((1 << NUM_CH_LOG2) < NUM_CH) || ((1 << DEPTH_LOG2) != DEPTH)) begin : g_param_check
      $error("multich_sample_fifo: inconsistent NUM_CH/DEPTH log2 parameters");
   end

   // A channel is held in reset by either the global or its own reset line.
   always_comb begin
      w_ch_rst = {NUM_CH{rst}} | rst_ch;
   end

   // One self-contained FIFO per channel; channels share nothing but the clock.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sample_fifo_ch #(
         .DEPTH      (DEPTH),
         .DEPTH_LOG2 (DEPTH_LOG2)
      ) u_ch (
         .clk        (clk),
         .i_rst      (w_ch_rst[g]),
         .i_wr_en    (bus.wr_en_i[g]),
         .i_wr_data  (bus.wr_data_i[g*SAMPLE_W +: SAMPLE_W]),
         .i_pop      (bus.pop_i[g]),
         .o_full     (w_full[g]),
         .o_ack      (w_ack[g]),
         .o_data     (w_data[g*SAMPLE_W +: SAMPLE_W]),
         .o_underrun (w_underrun[g]),
         .o_overflow (w_overflow[g]),
         .o_level    (w_level[g*LW +: LW])
      );
   end

   // Drive the interface outputs from the collected per-channel results.
   always_comb begin
      bus.full_o     = w_full;
      bus.ack_o      = w_ack;
      bus.data_o     = w_data;
      bus.underrun_o = w_underrun;
      bus.overflow_o = w_overflow;
      bus.level_o    = w_level;
   end

endmodule

// File: tb/tb_multich_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_multich_sample_fifo
// Self-checking bench for multich_sample_fifo. A queue-per-channel reference
// model tracks expected contents, responses and flags; directed scenarios and
// a randomized run are compared against it and against fixed constants.
// -----------------------------------------------------------------------------
module tb_multich_sample_fifo;
   import multich_sample_fifo_pkg::*;

   localparam int NUM_CH      = 2;
   localparam int NUM_CH_LOG2 = 1;
   localparam int DEPTH       = 16;
   localparam int DEPTH_LOG2  = 4;
   localparam int LW          = DEPTH_LOG2 + 1;

   logic                                clk = 1'b0;
   logic                                rst = 1'b1;
   logic [NUM_CH-1:0]                   rst_ch = '0;
   logic [NUM_CH-1:0]                   wr_en = '0;
   logic [NUM_CH-1:0]                   pop = '0;
   logic [NUM_CH-1:0][SAMPLE_W-1:0]     wdata = '0;

   int errors = 0;
   int checks = 0;

   // Reference model: FIFO contents plus the response expected after each edge.
   sample_t mq [NUM_CH][$];
   bit      m_ack   [NUM_CH];
   bit      m_under [NUM_CH];
   bit      m_over  [NUM_CH];
   sample_t m_data  [NUM_CH];

   multich_sample_fifo_if #(.NUM_CH(NUM_CH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

   assign bus.wr_en_i   = wr_en;
   assign bus.pop_i     = pop;
   assign bus.wr_data_i = wdata;

   multich_sample_fifo #(
      .NUM_CH      (NUM_CH),
      .NUM_CH_LOG2 (NUM_CH_LOG2),
      .DEPTH       (DEPTH),
      .DEPTH_LOG2  (DEPTH_LOG2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .rst_ch (rst_ch),
      .bus    (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   function automatic sample_t out_data(int c);
      return bus.data_o[c*SAMPLE_W +: SAMPLE_W];
   endfunction

   function automatic logic [LW-1:0] out_level(int c);
      return bus.level_o[c*LW +: LW];
   endfunction

   // Pulses are visible only while the channel is not being held in reset.
   function automatic bit in_rst(int c);
      return rst || rst_ch[c];
   endfunction

   // Advance one clock: the model consumes the inputs present at the edge
   // (pop first, then push; overflow decided on the pre-edge occupancy), then
   // the bench waits until just after the edge so outputs can be sampled.
   task automatic applyStimulus();
      for (int c = 0; c < NUM_CH; c++) begin
         if (in_rst(c)) begin
            mq[c].delete();
            m_ack[c] = 0; m_under[c] = 0; m_over[c] = 0; m_data[c] = '0;
         end else begin
            int sz = mq[c].size();
            m_ack[c]   = pop[c];
            m_under[c] = pop[c] && (sz == 0);
            m_over[c]  = wr_en[c] && (sz == DEPTH) && !pop[c];
            if (pop[c]) m_data[c] = (sz > 0) ? mq[c].pop_front() : '0;
            if (wr_en[c] && ((sz < DEPTH) || pop[c])) mq[c].push_back(wdata[c]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      wr_en = '0; pop = '0;
      repeat (n) applyStimulus();
   endtask

   // Reset clears everything and blocks pushes/pops while asserted.
   task automatic test_reset();
      rst = 1'b1; wr_en = '1; pop = '1; wdata = {24'h123456, 24'h654321};
      repeat (3) applyStimulus();
      checks++; if (bus.ack_o !== '0) begin errors++; $display("[TB] FAIL reset_ack got=%b exp=0", bus.ack_o); end
      checks++; if (bus.data_o !== '0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", bus.data_o); end
      checks++; if (bus.level_o !== '0) begin errors++; $display("[TB] FAIL reset_level got=%h exp=0", bus.level_o); end
      checks++; if ({bus.underrun_o, bus.overflow_o, bus.full_o} !== '0) begin errors++; $display("[TB] FAIL reset_flags got=%b exp=0", {bus.underrun_o, bus.overflow_o, bus.full_o}); end
      rst = 1'b0; wr_en = '0; pop = '0; wdata = '0;
      applyStimulus();
      checks++; if (bus.ack_o !== '0) begin errors++; $display("[TB] FAIL post_reset_ack got=%b exp=0", bus.ack_o); end
   endtask

   // Three pushes on ch0, then three widely spaced pops: one-cycle latency,
   // data in order, held between acks, ch1 untouched.
   task automatic test_basic_order();
      for (int i = 1; i <= 3; i++) begin
         wr_en = 2'b01; wdata[0] = 24'(i);
         applyStimulus();
      end
      idle(1);
      checks++; if (out_level(0) !== 5'd3) begin errors++; $display("[TB] FAIL basic_level got=%0d exp=3", out_level(0)); end
      for (int k = 0; k < 3; k++) begin
         pop = 2'b01;
         checks++; if (bus.ack_o !== 2'b00) begin errors++; $display("[TB] FAIL basic_early_ack got=%b exp=00", bus.ack_o); end
         applyStimulus();
         pop = 2'b00;
         checks++; if (bus.ack_o !== 2'b01) begin errors++; $display("[TB] FAIL basic_ack got=%b exp=01", bus.ack_o); end
         checks++; if (out_data(0) !== 24'(k+1)) begin errors++; $display("[TB] FAIL basic_data got=%h exp=%h", out_data(0), 24'(k+1)); end
         repeat (63) applyStimulus();
         checks++; if (bus.ack_o !== 2'b00 || out_data(0) !== 24'(k+1)) begin errors++; $display("[TB] FAIL basic_hold ack=%b data=%h exp ack=00 data=%h", bus.ack_o, out_data(0), 24'(k+1)); end
      end
      checks++; if (out_level(0) !== 5'd0) begin errors++; $display("[TB] FAIL basic_final_level got=%0d exp=0", out_level(0)); end
   endtask

   // Pop on an empty channel: acked with zero data and an underrun pulse.
   task automatic test_underrun();
      pop = 2'b10;
      applyStimulus();
      pop = 2'b00;
      checks++; if (bus.ack_o !== 2'b10) begin errors++; $display("[TB] FAIL underrun_ack got=%b exp=10", bus.ack_o); end
      checks++; if (out_data(1) !== 24'h000000) begin errors++; $display("[TB] FAIL underrun_data got=%h exp=000000", out_data(1)); end
      checks++; if (bus.underrun_o !== 2'b10) begin errors++; $display("[TB] FAIL underrun_pulse got=%b exp=10", bus.underrun_o); end
      checks++; if (out_level(1) !== 5'd0) begin errors++; $display("[TB] FAIL underrun_level got=%0d exp=0", out_level(1)); end
      applyStimulus();
      checks++; if (bus.underrun_o !== 2'b00 || bus.ack_o !== 2'b00) begin errors++; $display("[TB] FAIL underrun_one_cycle und=%b ack=%b exp 00/00", bus.underrun_o, bus.ack_o); end
   endtask

   // Fill ch0 to 17 pushes, then push+pop at full, then drain back-to-back.
   task automatic test_full_overflow();
      for (int i = 1; i <= 17; i++) begin
         wr_en = 2'b01; wdata[0] = 24'(i);
         applyStimulus();
         if (i == 15) begin
            checks++; if (bus.full_o[0] !== 1'b0) begin errors++; $display("[TB] FAIL full_early got=%b exp=0", bus.full_o[0]); end
         end
         if (i == 16) begin
            checks++; if (bus.full_o[0] !== 1'b1 || bus.overflow_o[0] !== 1'b0) begin errors++; $display("[TB] FAIL full_at16 full=%b ovf=%b exp 1/0", bus.full_o[0], bus.overflow_o[0]); end
         end
      end
      wr_en = 2'b00;
      checks++; if (bus.overflow_o !== 2'b01) begin errors++; $display("[TB] FAIL overflow_pulse got=%b exp=01", bus.overflow_o); end
      checks++; if (out_level(0) !== 5'd16) begin errors++; $display("[TB] FAIL overflow_level got=%0d exp=16", out_level(0)); end
      applyStimulus();
      checks++; if (bus.overflow_o !== 2'b00) begin errors++; $display("[TB] FAIL overflow_one_cycle got=%b exp=00", bus.overflow_o); end

      wr_en = 2'b01; pop = 2'b01; wdata[0] = 24'hABCDEF;
      applyStimulus();
      wr_en = 2'b00;
      checks++; if (bus.ack_o[0] !== 1'b1 || out_data(0) !== 24'd1) begin errors++; $display("[TB] FAIL full_pushpop ack=%b data=%h exp 1/000001", bus.ack_o[0], out_data(0)); end
      checks++; if (out_level(0) !== 5'd16 || bus.full_o[0] !== 1'b1) begin errors++; $display("[TB] FAIL full_pushpop_level got=%0d exp=16", out_level(0)); end

      for (int i = 0; i < 16; i++) begin
         sample_t exp_d = (i < 15) ? 24'(i + 2) : 24'hABCDEF;
         applyStimulus();
         checks++; if (bus.ack_o[0] !== 1'b1 || out_data(0) !== exp_d) begin errors++; $display("[TB] FAIL drain_%0d ack=%b data=%h exp 1/%h", i, bus.ack_o[0], out_data(0), exp_d); end
      end
      pop = 2'b00;
      applyStimulus();
      checks++; if (out_level(0) !== 5'd0 || bus.ack_o !== 2'b00) begin errors++; $display("[TB] FAIL drain_end level=%0d ack=%b exp 0/00", out_level(0), bus.ack_o); end
   endtask

   // 20 random words through ch0 across the pointer wrap point.
   task automatic test_wrap();
      sample_t words [$];
      int      nr = 0;
      for (int i = 0; i < 20; i++) words.push_back(24'($urandom));
      for (int t = 0; t < 30; t++) begin
         wr_en = (t < 20) ? 2'b01 : 2'b00;
         pop   = (t >= 10) ? 2'b01 : 2'b00;
         wdata[0] = (t < 20) ? words[t] : '0;
         applyStimulus();
         if (t >= 10) begin
            checks++; if (bus.ack_o[0] !== 1'b1 || out_data(0) !== words[nr]) begin errors++; $display("[TB] FAIL wrap_%0d ack=%b data=%h exp 1/%h", nr, bus.ack_o[0], out_data(0), words[nr]); end
            nr++;
         end
      end
      idle(1);
      checks++; if (out_level(0) !== 5'd0) begin errors++; $display("[TB] FAIL wrap_level got=%0d exp=0", out_level(0)); end
   endtask

   // Per-channel reset cancels a pop sampled with it and masks a due ack.
   task automatic test_reset_on_ack();
      wr_en = 2'b11; wdata = {24'h222222, 24'h111111};
      applyStimulus();
      wr_en = 2'b01; wdata[0] = 24'h333333;
      applyStimulus();
      wr_en = 2'b00; pop = 2'b11;
      applyStimulus();
      pop = 2'b00; rst_ch = 2'b01;
      #1;
      checks++; if (bus.ack_o !== 2'b10) begin errors++; $display("[TB] FAIL rstack_mask got=%b exp=10", bus.ack_o); end
      checks++; if (out_data(1) !== 24'h222222) begin errors++; $display("[TB] FAIL rstack_ch1_data got=%h exp=222222", out_data(1)); end
      applyStimulus();
      rst_ch = 2'b00;
      checks++; if (out_level(0) !== 5'd0 || out_data(0) !== 24'h0) begin errors++; $display("[TB] FAIL rstack_ch0_clear level=%0d data=%h exp 0/000000", out_level(0), out_data(0)); end

      wr_en = 2'b10; wdata[1] = 24'h444444;
      applyStimulus();
      wr_en = 2'b00; pop = 2'b10; rst_ch = 2'b10;
      applyStimulus();
      pop = 2'b00; rst_ch = 2'b00;
      checks++; if (bus.ack_o !== 2'b00 || out_level(1) !== 5'd0) begin errors++; $display("[TB] FAIL rstpop_cancel ack=%b level=%0d exp 00/0", bus.ack_o, out_level(1)); end
   endtask

   // Random pushes, pops and occasional resets on both channels, checked every
   // cycle against the queue model. Phases bias towards filling or draining.
   task automatic test_random();
      for (int t = 0; t < 800; t++) begin
         bit fill = ((t / 100) % 2) == 0;
         for (int c = 0; c < NUM_CH; c++) begin
            wr_en[c]  = fill ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            pop[c]    = fill ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            wdata[c]  = 24'($urandom);
            rst_ch[c] = ($urandom_range(63) == 0);
         end
         rst = ($urandom_range(255) == 0);
         applyStimulus();
         for (int c = 0; c < NUM_CH; c++) begin
            bit      e_ack = m_ack[c]   && !in_rst(c);
            bit      e_und = m_under[c] && !in_rst(c);
            bit      e_ovf = m_over[c]  && !in_rst(c);
            int      e_lvl = mq[c].size();
            checks++;
            if (bus.ack_o[c] !== e_ack || bus.underrun_o[c] !== e_und || bus.overflow_o[c] !== e_ovf ||
                out_data(c) !== m_data[c] || out_level(c) !== LW'(e_lvl) || bus.full_o[c] !== (e_lvl == DEPTH)) begin
               errors++;
               $display("[TB] FAIL random_t%0d_ch%0d got ack=%b und=%b ovf=%b data=%h lvl=%0d full=%b exp ack=%b und=%b ovf=%b data=%h lvl=%0d",
                        t, c, bus.ack_o[c], bus.underrun_o[c], bus.overflow_o[c], out_data(c), out_level(c), bus.full_o[c],
                        e_ack, e_und, e_ovf, m_data[c], e_lvl);
            end
         end
      end
      rst = 1'b0; rst_ch = '0;
      idle(2);
   endtask

   initial begin
      test_reset();
      test_basic_order();
      test_underrun();
      test_full_overflow();
      test_wrap();
      test_reset_on_ack();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
